// File: rtl/tft_char_render.sv
// rtl/tft_char_render.sv - renders one scaled 8x16 glyph into a TFT scan stream
//
// Purpose: sits in front of a 128x1 glyph ROM. Tracks the glyph position with
// sub-pixel / glyph-cell counters driven by the scan stream, issues the ROM
// address, and merges the registered ROM bit into RGB565 output pixels that
// stay aligned with the delayed DE/HS/VS.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   de_in        data enable (visible pixel)
//   hs_in        hsync, delayed to hs_out
//   vs_in        vsync (active level VS_POL), clears vertical position
//   x_in, y_in   current pixel coordinates, valid with de_in
//   fg_color     RGB565 for glyph bit 1
//   bg_color     RGB565 for glyph bit 0 and outside the glyph window
//   rom_address  {row[3:0], col[2:0]} to the glyph ROM
//   rom_q        ROM bit, one clock after rom_address
//   de_out, hs_out, vs_out   inputs delayed 3 clocks
//   rgb_out      pixel colour aligned with de_out
module tft_char_render #(
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int X0     = 100,
    parameter int Y0     = 50,
    parameter int SCALE  = 2,
    parameter int VS_POL = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          de_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic [15:0]   fg_color,
    input  logic [15:0]   bg_color,
    output logic [6:0]    rom_address,
    input  logic          rom_q,
    output logic          de_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic [15:0]   rgb_out
);

    // Window bounds in widened arithmetic so X0 + 8*SCALE cannot wrap.
    localparam logic [XW+3:0] X_LO    = (XW + 4)'(X0);
    localparam logic [XW+3:0] X_HI    = (XW + 4)'(X0 + 8 * SCALE);
    localparam logic [YW+4:0] Y_LO    = (YW + 5)'(Y0);
    localparam logic [YW+4:0] Y_HI    = (YW + 5)'(Y0 + 16 * SCALE);
    localparam logic [2:0]    SUB_MAX = 3'(SCALE - 1);
    localparam logic          VS_ACT  = (VS_POL != 0);

    logic [XW+3:0] x_ext;
    logic [YW+4:0] y_ext;
    logic          in_x;
    logic          in_y;
    logic          active;

    assign x_ext  = {4'b0000, x_in};
    assign y_ext  = {5'b00000, y_in};
    assign in_x   = (x_ext >= X_LO) && (x_ext < X_HI);
    assign in_y   = (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign active = de_in && in_x && in_y;

    // Horizontal position: hsub counts the SCALE repeats of one glyph column.
    logic [2:0] hsub;
    logic [2:0] col;

    always_ff @(posedge clock) begin
        if (reset) begin
            hsub <= 3'd0;
            col  <= 3'd0;
        end else if (!de_in || !in_x) begin
            // Any gap or pixel left of/right of the window restarts the glyph row.
            hsub <= 3'd0;
            col  <= 3'd0;
        end else if (in_y) begin
            if (hsub == SUB_MAX) begin
                hsub <= 3'd0;
                if (col != 3'd7) begin
                    col <= col + 3'd1;
                end
            end else begin
                hsub <= hsub + 3'd1;
            end
        end
    end

    // Vertical position advances on the DE falling edge of each line that
    // touched the window rows; line_hit remembers that for the current line.
    logic [2:0] vsub;
    logic [3:0] row;
    logic       de_d;
    logic       line_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            vsub     <= 3'd0;
            row      <= 4'd0;
            de_d     <= 1'b0;
            line_hit <= 1'b0;
        end else begin
            de_d <= de_in;
            if (vs_in == VS_ACT) begin
                vsub     <= 3'd0;
                row      <= 4'd0;
                line_hit <= 1'b0;
            end else if (de_d && !de_in) begin
                line_hit <= 1'b0;
                if (line_hit) begin
                    if (vsub == SUB_MAX) begin
                        vsub <= 3'd0;
                        if (row != 4'd15) begin
                            row <= row + 4'd1;
                        end
                    end else begin
                        vsub <= vsub + 3'd1;
                    end
                end
            end else if (de_in && in_y) begin
                line_hit <= 1'b1;
            end
        end
    end

    // Stage 1: ROM address (held outside the window), window flag, syncs.
    logic win1, de1, hs1, vs1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_address <= 7'd0;
            win1        <= 1'b0;
            de1         <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
        end else begin
            if (active) begin
                rom_address <= {row, col};
            end
            win1 <= active;
            de1  <= de_in;
            hs1  <= hs_in;
            vs1  <= vs_in;
        end
    end

    // Stage 2: the ROM registers its bit while the flags move along.
    logic win2, de2, hs2, vs2;

    always_ff @(posedge clock) begin
        if (reset) begin
            win2 <= 1'b0;
            de2  <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
        end else begin
            win2 <= win1;
            de2  <= de1;
            hs2  <= hs1;
            vs2  <= vs1;
        end
    end

    // Stage 3: colour select; fg/bg are used live here.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_out <= 16'd0;
            de_out  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
        end else begin
            if (!de2) begin
                rgb_out <= 16'd0;
            end else if (win2 && rom_q) begin
                rgb_out <= fg_color;
            end else begin
                rgb_out <= bg_color;
            end
            de_out <= de2;
            hs_out <= hs2;
            vs_out <= vs2;
        end
    end

endmodule

// File: tb/tb_tft_char_render.sv
// tb/tb_tft_char_render.sv - directed bench for tft_char_render (SCALE 1 and 2)
module tb_tft_char_render;

    localparam int X0 = 100;
    localparam int Y0 = 50;

    logic        clock = 1'b0;
    logic        reset;
    logic        de, hs, vs;
    logic [9:0]  x, y;
    logic [15:0] fg, bg;

    logic [6:0]  ra1, ra2;
    logic        rq1, rq2;
    logic        de1, hs1, vs1, de2, hs2, vs2;
    logic [15:0] rgb1, rgb2;

    always #5 clock = ~clock;

    tft_char_render #(.XW(10), .YW(10), .X0(X0), .Y0(Y0), .SCALE(1), .VS_POL(0)) dut1 (
        .clock(clock), .reset(reset), .de_in(de), .hs_in(hs), .vs_in(vs),
        .x_in(x), .y_in(y), .fg_color(fg), .bg_color(bg),
        .rom_address(ra1), .rom_q(rq1),
        .de_out(de1), .hs_out(hs1), .vs_out(vs1), .rgb_out(rgb1)
    );

    tft_char_render #(.XW(10), .YW(10), .X0(X0), .Y0(Y0), .SCALE(2), .VS_POL(0)) dut2 (
        .clock(clock), .reset(reset), .de_in(de), .hs_in(hs), .vs_in(vs),
        .x_in(x), .y_in(y), .fg_color(fg), .bg_color(bg),
        .rom_address(ra2), .rom_q(rq2),
        .de_out(de2), .hs_out(hs2), .vs_out(vs2), .rgb_out(rgb2)
    );

    function automatic logic glyph_bit(input logic [6:0] a);
        logic [15:0] v;
        v = 16'(a) * 16'd37 + 16'd5;
        return v[3];
    endfunction

    always @(posedge clock) begin
        rq1 <= glyph_bit(ra1);
        rq2 <= glyph_bit(ra2);
    end

    int nchk = 0;
    int nerr = 0;

    // Position reference for the model: glyph cell = (coord - start) / scale.
    int xs = X0;
    int ys = Y0;
    int ro1 = 0;
    int ro2 = 0;

    function automatic logic model(input int s, input int xv, input int yv, input logic dv,
                                   input int xs_, input int ys_, input int ro_);
        int  c, r;
        logic w;
        w = dv && (xv >= X0) && (xv < X0 + 8 * s) && (yv >= Y0) && (yv < Y0 + 16 * s);
        c = (xv - xs_) / s;
        r = (yv - ys_) / s + ro_;
        if (c < 0) c = 0;
        if (c > 7) c = 7;
        if (r < 0) r = 0;
        if (r > 15) r = 15;
        return w && glyph_bit(7'(r * 8 + c));
    endfunction

    logic pde[3], phs[3], pvs[3], pb1[3], pb2[3];
    int   px[3], py[3];

    logic [37:0] log_obs[$];
    logic [37:0] log_exp[$];
    int          log_x[$];
    int          log_y[$];

    task automatic cycle();
        logic [15:0] e1, e2;
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pde[i] = 1'b0; phs[i] = 1'b0; pvs[i] = 1'b0;
                pb1[i] = 1'b0; pb2[i] = 1'b0; px[i] = -1; py[i] = -1;
            end
        end else begin
            for (int i = 2; i > 0; i--) begin
                pde[i] = pde[i-1]; phs[i] = phs[i-1]; pvs[i] = pvs[i-1];
                pb1[i] = pb1[i-1]; pb2[i] = pb2[i-1]; px[i] = px[i-1]; py[i] = py[i-1];
            end
            pde[0] = de; phs[0] = hs; pvs[0] = vs;
            pb1[0] = model(1, int'(x), int'(y), de, xs, ys, ro1);
            pb2[0] = model(2, int'(x), int'(y), de, xs, ys, ro2);
            px[0] = de ? int'(x) : -1;
            py[0] = de ? int'(y) : -1;
        end
        #1;
        e1 = !pde[2] ? 16'd0 : (pb1[2] ? fg : bg);
        e2 = !pde[2] ? 16'd0 : (pb2[2] ? fg : bg);
        log_exp.push_back({pde[2], phs[2], pvs[2], e1, pde[2], phs[2], pvs[2], e2});
        log_obs.push_back({de1, hs1, vs1, rgb1, de2, hs2, vs2, rgb2});
        log_x.push_back(px[2]);
        log_y.push_back(py[2]);
    endtask

    task automatic clear_log();
        log_obs.delete(); log_exp.delete(); log_x.delete(); log_y.delete();
    endtask

    task automatic drive_pixels(input int yv, input int xa, input int xb);
        for (int xv = xa; xv <= xb; xv++) begin
            de = 1'b1;
            x  = 10'(xv);
            y  = 10'(yv);
            cycle();
        end
    endtask

    task automatic blank(input int n);
        de = 1'b0;
        for (int i = 0; i < n; i++) begin
            hs = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            cycle();
        end
        hs = 1'b1;
    endtask

    task automatic vs_pulse();
        de = 1'b0;
        vs = 1'b0;
        cycle();
        cycle();
        vs = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; de = 1'b1; hs = 1'b1; vs = 1'b1;
        x = 10'd105; y = 10'd10; fg = 16'hFFFF; bg = 16'h001F;
        for (int i = 0; i < 2; i++) begin
            cycle();
            nchk++;
            if ({ra1, ra2, de1, hs1, vs1, rgb1, de2, hs2, vs2, rgb2} !== 52'd0) begin
                nerr++;
                $display("FAIL reset_outputs[%0d] got ra1=%h ra2=%h de=%b%b hs=%b%b vs=%b%b rgb=%h/%h required all 0",
                         i, ra1, ra2, de1, de2, hs1, hs2, vs1, vs2, rgb1, rgb2);
            end
        end
        reset = 1'b0; de = 1'b0;
        cycle();
        cycle();
        de = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            nchk++;
            if ({de1, de2} !== ((i == 2) ? 2'b11 : 2'b00)) begin
                nerr++;
                $display("FAIL first_de_latency[%0d] got de_out=%b%b required %b", i, de1, de2, (i == 2));
            end
        end
        nchk++;
        if ({rgb1, rgb2} !== {16'h001F, 16'h001F}) begin
            nerr++;
            $display("FAIL first_pixel_outside got %h/%h required 001f/001f", rgb1, rgb2);
        end
        blank(4);
    endtask

    task automatic test_frame();
        clear_log();
        vs_pulse();
        for (int yv = 46; yv <= 84; yv++) begin
            if (yv == 52) begin
                drive_pixels(yv, 94, 103);
                fg = 16'hF800;
                drive_pixels(yv, 104, 120);
            end else if (yv == 53) begin
                drive_pixels(yv, 94, 103);
                nchk++;
                if (ra1 !== 7'd27) begin
                    nerr++;
                    $display("FAIL rom_addr_s1_103_53 got %0d required 27", ra1);
                end
                nchk++;
                if (ra2 !== 7'd9) begin
                    nerr++;
                    $display("FAIL rom_addr_s2_103_53 got %0d required 9", ra2);
                end
                drive_pixels(yv, 104, 120);
            end else begin
                drive_pixels(yv, 94, 120);
            end
            blank(4);
        end
        blank(3);
        foreach (log_obs[i]) begin
            nchk++;
            if (log_obs[i] !== log_exp[i]) begin
                nerr++;
                if (nerr < 20)
                    $display("FAIL frame_pixel[%0d] x=%0d y=%0d got %h required %h",
                             i, log_x[i], log_y[i], log_obs[i], log_exp[i]);
            end
            if (log_y[i] == 50 && (log_x[i] == 116 || log_x[i] == 99)) begin
                nchk++;
                if (log_obs[i][15:0] !== 16'h001F) begin
                    nerr++;
                    $display("FAIL s2_edge_bg x=%0d got %h required 001f", log_x[i], log_obs[i][15:0]);
                end
            end
        end
        fg = 16'hFFFF;
    endtask

    task automatic test_vs_midframe();
        clear_log();
        vs_pulse();
        for (int yv = 46; yv <= 59; yv++) begin
            drive_pixels(yv, 94, 120);
            blank(4);
        end
        vs_pulse();
        ys = 60;
        for (int yv = 60; yv <= 84; yv++) begin
            drive_pixels(yv, 94, 120);
            blank(4);
        end
        blank(3);
        ys = Y0;
        foreach (log_obs[i]) begin
            nchk++;
            if (log_obs[i] !== log_exp[i]) begin
                nerr++;
                if (nerr < 20)
                    $display("FAIL vs_mid_pixel[%0d] x=%0d y=%0d got %h required %h",
                             i, log_x[i], log_y[i], log_obs[i], log_exp[i]);
            end
        end
    endtask

    task automatic test_jump();
        clear_log();
        vs_pulse();
        drive_pixels(50, 96, 101);
        de = 1'b0;
        cycle();
        cycle();
        xs = 106; ro1 = 1; ro2 = 0;
        drive_pixels(50, 106, 106);
        nchk++;
        if (ra1 !== 7'd8) begin
            nerr++;
            $display("FAIL jump_addr_s1 got %0d required 8", ra1);
        end
        nchk++;
        if (ra2 !== 7'd0) begin
            nerr++;
            $display("FAIL jump_addr_s2 got %0d required 0", ra2);
        end
        drive_pixels(50, 107, 117);
        blank(6);
        xs = X0; ro1 = 0;
        foreach (log_obs[i]) begin
            nchk++;
            if (log_obs[i] !== log_exp[i]) begin
                nerr++;
                if (nerr < 20)
                    $display("FAIL jump_pixel[%0d] x=%0d y=%0d got %h required %h",
                             i, log_x[i], log_y[i], log_obs[i], log_exp[i]);
            end
        end
    endtask

    task automatic test_reset_flush();
        drive_pixels(10, 100, 105);
        reset = 1'b1;
        x = 10'd106;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 10'(107 + i);
            nchk++;
            if (i < 3) begin
                if ({de1, de2, rgb1, rgb2} !== 34'd0) begin
                    nerr++;
                    $display("FAIL flush_zero[%0d] got de=%b%b rgb=%h/%h required 0", i, de1, de2, rgb1, rgb2);
                end
            end else begin
                if ({de1, de2, rgb1, rgb2} !== {2'b11, 16'h001F, 16'h001F}) begin
                    nerr++;
                    $display("FAIL flush_resume got de=%b%b rgb=%h/%h required 11 001f/001f", de1, de2, rgb1, rgb2);
                end
            end
            cycle();
        end
        blank(4);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pde[i] = 1'b0; phs[i] = 1'b0; pvs[i] = 1'b0;
            pb1[i] = 1'b0; pb2[i] = 1'b0; px[i] = -1; py[i] = -1;
        end
        test_reset();
        test_frame();
        test_vs_midframe();
        test_jump();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/tft_char_render.md
Name: tft_char_render

Overview:
- Pixel-pipeline stage directly upstream of the 128x1 glyph ROMs.
- Takes the TFT scan stream (DE/HS/VS plus pixel coordinates) and places one 8x16 glyph at a fixed screen origin, magnified by an integer factor.
- Drives the glyph ROM address and consumes its 1-bit registered output.
- Emits RGB565 pixels aligned with the delayed sync signals to the panel driver.

Parameters:
- XW, 10, width of x_in.
- YW, 10, width of y_in.
- X0, 100, left pixel column of the glyph window.
- Y0, 50, top pixel row of the glyph window.
- SCALE, 2, magnification in both axes; legal 1..8.
- VS_POL, 0, active level of vs_in (0 = active-low).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- de_in  in  1  data-enable, high for visible pixels.
- hs_in  in  1  hsync, passed through.
- vs_in  in  1  vsync, passed through; frame start.
- x_in  in  XW  current pixel column (valid when de_in=1).
- y_in  in  YW  current pixel row (valid when de_in=1).
- fg_color  in  16  RGB565 for glyph bit = 1.
- bg_color  in  16  RGB565 for glyph bit = 0 and for window exterior.
- rom_address  out  7  glyph ROM address = {row[3:0], col[2:0]}; col 0 is leftmost.
- rom_q  in  1  glyph ROM data, valid one clock after rom_address.
- de_out  out  1  de_in delayed 3 clocks.
- hs_out  out  1  hs_in delayed 3 clocks.
- vs_out  out  1  vs_in delayed 3 clocks.
- rgb_out  out  16  pixel colour aligned with de_out.

Behaviour:
- Reset:
  - All outputs, including rom_address, are 0.
  - Counters cleared; pipeline flags cleared.
- Window: in_x = (x_in >= X0) && (x_in < X0 + 8*SCALE); in_y = (y_in >= Y0) && (y_in < Y0 + 16*SCALE). Compare arithmetic is XW+4 / YW+5 bits wide, so no overflow.
- Horizontal counters hsub (0..SCALE-1) and col (0..7):
  - Cleared whenever de_in=0 or in_x=0.
  - Each clock with de_in && in_x && in_y: hsub increments; when hsub wraps SCALE-1 -> 0, col increments.
  - col saturates at 7 (only reachable on the last subpixel).
- Vertical counters vsub (0..SCALE-1) and row (0..15):
  - Cleared while vs_in == VS_POL.
  - Advance once per line on the de_in falling edge (de_in delayed 1 = 1, de_in = 0) if that line had in_y=1. vsub wraps at SCALE-1 and increments row.
  - row saturates at 15.
- No division is used; position comes only from the counters.
- Stage 1 (edge 1): rom_address <= {row, col} using the current counter values; win1 <= de_in && in_x && in_y; de/hs/vs delayed.
  - If win1 would be 0, rom_address holds its previous value.
- Stage 2 (edge 2): ROM registers rom_q; win2 <= win1; syncs delayed.
- Stage 3 (edge 3): rgb_out <= !de2 ? 0 : (win2 ? (rom_q ? fg_color : bg_color) : bg_color); de/hs/vs_out <= stage-2 values.
- Total latency: 3 clocks from inputs to rgb_out/de_out/hs_out/vs_out.
- fg_color / bg_color are sampled at stage 3, i.e. live; changing them mid-frame takes effect on the next output pixel.
- Boundary conditions:
  - x_in jumping into the window mid-line (non-contiguous DE) restarts hsub/col at 0.
  - vs_in asserted mid-frame resets vertical counters immediately; pipeline contents drain normally.
  - Reset mid-line flushes the pipeline: de_out=0 and rgb_out=0 for the 3 clocks after reset deasserts.
  - SCALE=1: hsub and vsub are permanently 0; col advances every pixel.

Test Plan:
- Reset held 2 clocks with active stream -> all outputs 0; first de_out=1 exactly 3 clocks after first de_in=1 post-reset.
- SCALE=1, X0=100, Y0=50, 800x480 timing, ROM modelled as 128x1 array -> rom_address at x=103,y=53 equals 7'd27. rgb_out equals fg_color exactly where the model bit is 1, else bg_color.
- SCALE=2 -> each glyph bit occupies a 2x2 pixel block; window spans x 100..115, y 50..81. Pixel (116,50) and (99,50) -> bg_color.
- de_in=0 cycles -> rgb_out=0, and hs_out/vs_out track inputs with 3-clock delay across full frame.
- vs_in pulse (VS_POL=0) inserted mid-window at y=60 -> next window line restarts at row 0; no X/rollover of row beyond 15.
- fg_color changed from 16'hFFFF to 16'hF800 mid-line -> change appears on rgb_out 0 clocks after it is sampled at stage 3, not retroactively.
